fsm_pair_sequencer: RTL and testbench

- Sequences the two sequence-detector FSM implementations, one-hot and binary, which share the serial input w.
- Holds both FSMs in reset, then clears them. Shifts a latched stimulus pattern onto w one bit per clk.
- Compares the two z outputs every cycle and counts detections and mismatches.
- Sits between board I/O and the FSM pair, replacing the manual switch/button stepping.

---
 rtl/fsm_pair_sequencer_pkg.sv | 35 +++
 rtl/fsm_pair_sequencer_if.sv | 40 ++++
 rtl/fsm_pair_sequencer_bit_serializer.sv | 47 ++++
 rtl/fsm_pair_sequencer.sv | 120 ++++++++++++
 tb/tb_fsm_pair_sequencer.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fsm_pair_sequencer_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fsm_pair_sequencer_pkg -- shared state type and helpers  (rev 1.0)
// ------------------------------------------------------------------
package fsm_pair_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_DRIVE = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int DEF_PATTERN_W = 16;
   localparam int DEF_CNT_W     = 8;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int len_width(input int n);
      return $clog2(n + 1);
   endfunction

   localparam int DEF_IDX_W = idx_width(DEF_PATTERN_W);

   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
      logic [31:0] max_v;
      max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (value >= max_v) ? value : value + 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_pair_sequencer_if.sv
`default_nettype none
// ------------------------------------------------------------------
// fsm_pair_sequencer_if -- control, status and FSM-pair signals (rev 1.0)
// ------------------------------------------------------------------
interface fsm_pair_sequencer_if
   import fsm_pair_sequencer_pkg::*;
#(
   parameter int PATTERN_W = DEF_PATTERN_W,
   parameter int CNT_W     = DEF_CNT_W
) ();
   localparam int LEN_W = len_width(PATTERN_W);
   localparam int IDX_W = idx_width(PATTERN_W);

   logic                 start;
   logic [PATTERN_W-1:0] pattern;
   logic [LEN_W-1:0]     len;
   logic                 z_onehot;
   logic                 z_binary;
   logic                 w;
   logic                 fsm_reset;
   logic                 busy;
   logic                 done;
   logic [CNT_W-1:0]     det_cnt;
   logic [CNT_W-1:0]     mis_cnt;
   logic [IDX_W-1:0]     first_mis_idx;
   logic                 mis_seen;

   // master is the sequencer; slave is the board / FSM-pair side
   modport master (
      input  start, pattern, len, z_onehot, z_binary,
      output w, fsm_reset, busy, done, det_cnt, mis_cnt, first_mis_idx, mis_seen
   );

   modport slave (
      output start, pattern, len, z_onehot, z_binary,
      input  w, fsm_reset, busy, done, det_cnt, mis_cnt, first_mis_idx, mis_seen
   );

endinterface
`default_nettype wire

// File: rtl/fsm_pair_sequencer_bit_serializer.sv
`default_nettype none
// ------------------------------------------------------------------
// fsm_pair_sequencer_bit_serializer -- latched pattern/length, bit index (rev 1.0)
// ------------------------------------------------------------------
module fsm_pair_sequencer_bit_serializer
   import fsm_pair_sequencer_pkg::*;
#(
   parameter int PATTERN_W = DEF_PATTERN_W,
   parameter int LEN_W     = len_width(DEF_PATTERN_W),
   parameter int IDX_W     = DEF_IDX_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 advance,
   input  logic [PATTERN_W-1:0] pattern,
   input  logic [LEN_W-1:0]     len,
   output logic                 bit_out,
   output logic                 last_bit,
   output logic [LEN_W-1:0]     idx
);
   logic [PATTERN_W-1:0] pat;
   logic [LEN_W-1:0]     len_q;
   logic [LEN_W-1:0]     len_eff;

   assign len_eff = ((len == '0) || (len > LEN_W'(PATTERN_W))) ? LEN_W'(PATTERN_W) : len;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pat   <= '0;
         len_q <= LEN_W'(PATTERN_W);
         idx   <= '0;
      end else if (load) begin
         pat   <= pattern;
         len_q <= len_eff;
         idx   <= '0;
      end else if (advance) begin
         idx   <= idx + LEN_W'(1);
      end
   end

   // idx points at the next bit to issue, so w carries bit idx-1
   assign bit_out  = pat[IDX_W'(idx)];
   assign last_bit = (idx == len_q);

endmodule
`default_nettype wire

// File: rtl/fsm_pair_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// fsm_pair_sequencer -- drives and cross-checks one-hot/binary FSM pair (rev 1.0)
// ------------------------------------------------------------------
module fsm_pair_sequencer
   import fsm_pair_sequencer_pkg::*;
#(
   parameter int PATTERN_W = DEF_PATTERN_W,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 reset,
   fsm_pair_sequencer_if.master bus
);
   localparam int LEN_W = len_width(PATTERN_W);
   localparam int IDX_W = idx_width(PATTERN_W);

   state_t           state;
   state_t           state_n;
   logic             load;
   logic             advance;
   logic             sample;
   logic             mismatch;
   logic             ser_bit;
   logic             last_bit;
   logic [LEN_W-1:0] ser_idx;
   logic [IDX_W-1:0] resp_idx;

   fsm_pair_sequencer_bit_serializer #(
      .PATTERN_W (PATTERN_W),
      .LEN_W     (LEN_W),
      .IDX_W     (IDX_W)
   ) u_serializer (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .advance  (advance),
      .pattern  (bus.pattern),
      .len      (bus.len),
      .bit_out  (ser_bit),
      .last_bit (last_bit),
      .idx      (ser_idx)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      advance = 1'b0;
      sample  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               state_n = S_CLR;
               load    = 1'b1;
            end
         end
         S_CLR: begin
            state_n = S_DRIVE;
            advance = 1'b1;
         end
         S_DRIVE: begin
            sample = (ser_idx >= LEN_W'(2));
            if (last_bit) state_n = S_DRAIN;
            else          advance = 1'b1;
         end
         S_DRAIN: begin
            sample  = 1'b1;
            state_n = S_DONE;
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // z answers the bit captured on the previous edge
   assign resp_idx = (state == S_DRAIN) ? IDX_W'(ser_idx - LEN_W'(1))
                                        : IDX_W'(ser_idx - LEN_W'(2));
   assign mismatch = (bus.z_onehot != bus.z_binary);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.w             <= 1'b0;
         bus.fsm_reset     <= 1'b1;
         bus.busy          <= 1'b0;
         bus.done          <= 1'b0;
         bus.det_cnt       <= '0;
         bus.mis_cnt       <= '0;
         bus.first_mis_idx <= '0;
         bus.mis_seen      <= 1'b0;
      end else begin
         bus.w         <= advance & ser_bit;
         bus.fsm_reset <= (state_n == S_CLR);
         bus.busy      <= (state_n == S_CLR) || (state_n == S_DRIVE) || (state_n == S_DRAIN);
         bus.done      <= (state == S_DONE);
         if (load) begin
            bus.det_cnt       <= '0;
            bus.mis_cnt       <= '0;
            bus.first_mis_idx <= '0;
            bus.mis_seen      <= 1'b0;
         end else if (sample) begin
            if (bus.z_onehot)
               bus.det_cnt <= CNT_W'(sat_inc(32'(bus.det_cnt), CNT_W));
            if (mismatch) begin
               bus.mis_cnt <= CNT_W'(sat_inc(32'(bus.mis_cnt), CNT_W));
               if (!bus.mis_seen) begin
                  bus.mis_seen      <= 1'b1;
                  bus.first_mis_idx <= resp_idx;
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fsm_pair_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fsm_pair_sequencer -- scoreboard bench, CNT_W=8 and CNT_W=2 instances (rev 1.0)
// ------------------------------------------------------------------
module tb_fsm_pair_sequencer;
   import fsm_pair_sequencer_pkg::*;

   localparam int PW = 16;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fsm_pair_sequencer_if #(.PATTERN_W(PW), .CNT_W(8)) bus8 ();
   fsm_pair_sequencer_if #(.PATTERN_W(PW), .CNT_W(2)) bus2 ();

   fsm_pair_sequencer #(.PATTERN_W(PW), .CNT_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
   fsm_pair_sequencer #(.PATTERN_W(PW), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

   logic          start   = 1'b0;
   logic [PW-1:0] pattern = '0;
   logic [4:0]    len     = '0;
   logic          z_on;
   logic          z_bin;

   assign bus8.start    = start;
   assign bus8.pattern  = pattern;
   assign bus8.len      = len;
   assign bus8.z_onehot = z_on;
   assign bus8.z_binary = z_bin;
   assign bus2.start    = start;
   assign bus2.pattern  = pattern;
   assign bus2.len      = len;
   assign bus2.z_onehot = z_on;
   assign bus2.z_binary = z_bin;

   // Stand-in for the FSM pair: counts captured bits since fsm_reset and
   // answers each one from per-run tables; garbage outside the run window.
   int            n      = 0;
   logic [63:0]   cap    = '0;
   logic          junk_a = 1'b0;
   logic          junk_b = 1'b0;
   logic [PW-1:0] ztab   = '0;
   logic [PW-1:0] ftab   = '0;
   int            run_l  = PW;

   always @(posedge clk) begin
      junk_a <= 1'($urandom);
      junk_b <= 1'($urandom);
      if (bus8.fsm_reset) begin
         n   <= 0;
         cap <= '0;
      end else begin
         if (n < 64) cap[6'(n)] <= bus8.w;
         if (n < 63) n <= n + 1;
      end
   end

   always_comb begin
      z_on  = junk_a;
      z_bin = junk_b;
      if (n >= 1 && n <= run_l) begin
         z_on  = ztab[4'(n - 1)];
         z_bin = ztab[4'(n - 1)] ^ ftab[4'(n - 1)];
      end
   end

   typedef struct {
      logic [PW-1:0] pat;
      int            l;
      int            det;
      int            mis;
      int            first;
      bit            seen;
      longint        done_cyc;
   } exp_t;

   exp_t   exp_q[$];
   exp_t   mon_e;
   longint cyc      = 0;
   int     n_checks = 0;
   int     n_pass   = 0;
   int     done_cnt = 0;
   int     busy_run = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic int eff_len(input logic [4:0] ln);
      return (ln == 5'd0 || int'(ln) > PW) ? PW : int'(ln);
   endfunction

   function automatic int sat(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   function automatic longint maskn(input int nb);
      return (longint'(1) << nb) - 1;
   endfunction

   // Expected run result from counting table bits over the first L responses
   function automatic exp_t model(input logic [PW-1:0] p, input logic [4:0] ln,
                                  input logic [PW-1:0] zt, input logic [PW-1:0] ft,
                                  input longint dc);
      exp_t e;
      e.pat = p; e.l = eff_len(ln); e.det = 0; e.mis = 0; e.first = 0; e.seen = 1'b0;
      e.done_cyc = dc;
      for (int i = 0; i < e.l; i++) begin
         if (zt[i]) e.det++;
         if (ft[i]) begin
            if (!e.seen) e.first = i;
            e.seen = 1'b1;
            e.mis++;
         end
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         busy_run = 0;
      end else begin
         if (bus8.busy) busy_run++;
         if (bus8.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("latency",     cyc, mon_e.done_cyc);
               chk("busy_cycles", busy_run, mon_e.l + 2);
               chk("w_stream",    longint'(cap) & maskn(mon_e.l + 1),
                                  longint'(mon_e.pat) & maskn(mon_e.l));
               chk("det8",   bus8.det_cnt,       sat(mon_e.det, 255));
               chk("mis8",   bus8.mis_cnt,       sat(mon_e.mis, 255));
               chk("first8", bus8.first_mis_idx, mon_e.first);
               chk("seen8",  bus8.mis_seen,      mon_e.seen);
               chk("det2",   bus2.det_cnt,       sat(mon_e.det, 3));
               chk("mis2",   bus2.mis_cnt,       sat(mon_e.mis, 3));
               chk("first2", bus2.first_mis_idx, mon_e.first);
               chk("seen2",  bus2.mis_seen,      mon_e.seen);
            end
            busy_run = 0;
         end
      end
   end

   task automatic run(input logic [PW-1:0] p, input logic [4:0] ln,
                      input logic [PW-1:0] zt, input logic [PW-1:0] ft);
      @(negedge clk);
      pattern = p;
      len     = ln;
      ztab    = zt;
      ftab    = ft;
      run_l   = eff_len(ln);
      start   = 1'b1;
      exp_q.push_back(model(p, ln, zt, ft, cyc + 1 + eff_len(ln) + 3));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0 = done_cnt;
      int i  = 0;
      while (done_cnt == d0 && i < budget) begin
         @(negedge clk);
         #1;
         i++;
      end
      if (done_cnt == d0) chk("done_timeout", 0, 1);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_fsm_reset8"}, bus8.fsm_reset, 1);
      chk({tag, "_busy8"},      bus8.busy, 0);
      chk({tag, "_done8"},      bus8.done, 0);
      chk({tag, "_w8"},         bus8.w, 0);
      chk({tag, "_det8"},       bus8.det_cnt, 0);
      chk({tag, "_mis8"},       bus8.mis_cnt, 0);
      chk({tag, "_first8"},     bus8.first_mis_idx, 0);
      chk({tag, "_seen8"},      bus8.mis_seen, 0);
      chk({tag, "_fsm_reset2"}, bus2.fsm_reset, 1);
      chk({tag, "_busy2"},      bus2.busy, 0);
      chk({tag, "_det2"},       bus2.det_cnt, 0);
   endtask

   initial begin
      logic [PW-1:0] p;
      int            d0;

      reset = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_reset_vals("por");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("release_fsm_reset8", bus8.fsm_reset, 0);
      chk("release_fsm_reset2", bus2.fsm_reset, 0);
      chk("release_busy8",      bus8.busy, 0);

      // Clean run: detections on responses to bits 7 and 8
      run(16'h00F0, 5'd0, 16'h0180, 16'h0000);
      wait_done(40);

      // Mismatch on responses to bits 5 and 9
      run(16'h0FFF, 5'd12, 16'($urandom), 16'h0220);
      wait_done(40);

      // Single-bit run
      run(16'h0001 | 16'($urandom << 1), 5'd1, 16'($urandom), 16'($urandom));
      wait_done(40);

      // Six detections, eight mismatches: the 2-bit counters saturate
      run(16'($urandom), 5'd16, 16'hA03C, 16'h00FF);
      wait_done(40);

      // Length above PATTERN_W falls back to the full width
      run(16'($urandom), 5'd25, 16'($urandom), 16'($urandom) & 16'($urandom));
      wait_done(40);

      // start and pattern/len change during DRIVE cycle 4 are ignored
      p  = 16'($urandom);
      d0 = done_cnt;
      run(p, 5'd16, 16'($urandom), 16'($urandom) & 16'($urandom));
      repeat (5) @(negedge clk);
      start   = 1'b1;
      pattern = ~p;
      len     = 5'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done(40);
      repeat (6) @(negedge clk);
      chk("single_done", done_cnt - d0, 1);

      // Reset dropped in DRIVE cycle 6
      run(16'($urandom), 5'd16, 16'($urandom), 16'($urandom));
      repeat (7) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      #1;
      check_reset_vals("midrun");
      d0 = done_cnt;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (25) @(negedge clk);
      chk("no_done_after_reset", done_cnt - d0, 0);

      run(16'($urandom), 5'd9, 16'($urandom), 16'h0100);
      wait_done(40);

      for (int k = 0; k < 16; k++) begin
         run(16'($urandom), 5'($urandom_range(0, 31)), 16'($urandom),
             16'($urandom) & 16'($urandom) & 16'($urandom));
         wait_done(40);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
